// File: rtl/apu_event_trigger.sv
// apu_event_trigger
//   Turns raw game-logic event levels into sound-enable windows measured in
//   video frames. Each channel has its own retrigger and an optional
//   hold-while-asserted mode. A test mode drives sound_on straight from
//   event_in. A fixed-priority selector names the lowest-numbered active
//   channel, for APUs that drive one voice at a time.
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   frame_end    one-cycle pulse at the end of each video frame
//   test_mode    1: sound_on <= event_in, windows bypassed
//   event_in     [NUM_CH] raw event levels
//   level_mode   [NUM_CH] 1: countdown frozen while event_in is high
//   sound_on     [NUM_CH] registered sound enable
//   trig_pulse   [NUM_CH] registered one-cycle (re)trigger pulse
//   sel_valid    any sound_on bit set (combinational)
//   sel_ch       [SEL_W] lowest index with sound_on set, 0 when none

// One channel: edge detect, frame countdown, trigger pulse.
module apu_event_ch #(
    parameter int HOLD_FRAMES = 2,
    parameter int CNT_W       = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_end,
    input  logic test_mode,
    input  logic event_in,
    input  logic level_mode,
    output logic sound_on,
    output logic trig_pulse
);
    logic             ev_prev;
    logic [CNT_W-1:0] cnt;
    logic             rise;

    assign rise = event_in & ~ev_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            ev_prev    <= 1'b0;
            cnt        <= '0;
            sound_on   <= 1'b0;
            trig_pulse <= 1'b0;
        end else begin
            // ev_prev tracks in both modes, so a level that is already high
            // when test mode ends is not seen as a new edge.
            ev_prev    <= event_in;
            trig_pulse <= 1'b0;
            if (test_mode) begin
                sound_on <= event_in;
                cnt      <= '0;
            end else if (rise) begin
                // A rise beats a same-cycle frame_end; that frame is not counted.
                sound_on   <= 1'b1;
                cnt        <= CNT_W'(HOLD_FRAMES);
                trig_pulse <= 1'b1;
            end else if (frame_end && sound_on) begin
                if (level_mode && event_in) begin
                    // Frozen while the event is held.
                end else if (cnt <= CNT_W'(1)) begin
                    // cnt==0 only occurs after leaving test mode; it expires
                    // at the next frame, just like cnt==1.
                    cnt      <= '0;
                    sound_on <= 1'b0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end
endmodule

module apu_event_trigger #(
    parameter int NUM_CH      = 3,
    parameter int HOLD_FRAMES = 2,
    parameter int CNT_W       = 2,
    parameter int SEL_W       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_end,
    input  logic              test_mode,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [NUM_CH-1:0] level_mode,
    output logic [NUM_CH-1:0] sound_on,
    output logic [NUM_CH-1:0] trig_pulse,
    output logic              sel_valid,
    output logic [SEL_W-1:0]  sel_ch
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        apu_event_ch #(
            .HOLD_FRAMES (HOLD_FRAMES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .frame_end  (frame_end),
            .test_mode  (test_mode),
            .event_in   (event_in[i]),
            .level_mode (level_mode[i]),
            .sound_on   (sound_on[i]),
            .trig_pulse (trig_pulse[i])
        );
    end

    assign sel_valid = |sound_on;

    // Scan from the top down so the lowest active index is written last.
    always_comb begin
        sel_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (sound_on[i]) sel_ch = SEL_W'(i);
        end
    end
endmodule
